// File: rtl/dma_tx_if.sv
// Bus-side signals of the TX DMA: transmit request, arbitration, RAM read port and
// transmitter byte handshake.
interface dma_tx_if;
   logic       Start;
   logic       Enable;
   logic       Bus_grant;
   logic [7:0] Databus_in;
   logic [7:0] Address;
   logic       Cs;
   logic       Oen;
   logic       Bus_req;
   logic [7:0] TX_Data;
   logic       Valid_D;
   logic       Ack_in;
   logic       Ready;

   modport master (
      input  Start, Enable, Bus_grant, Databus_in, Ack_in,
      output Address, Cs, Oen, Bus_req, TX_Data, Valid_D, Ready
   );

   modport slave (
      output Start, Enable, Bus_grant, Databus_in, Ack_in,
      input  Address, Cs, Oen, Bus_req, TX_Data, Valid_D, Ready
   );
endinterface

// File: rtl/dma_tx.sv
// TX DMA: reads a length byte and then that many payload bytes from RAM, handing each
// byte to the serial transmitter with a valid/ack handshake.
module dma_tx #(
   parameter logic [7:0] LEN_ADDR  = 8'h03,
   parameter logic [7:0] BASE_ADDR = 8'h04
) (
   input logic      Clk,
   input logic      Rst,
   dma_tx_if.master bus
);

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StRdLen,
      StLatLen,
      StRdData,
      StLatData,
      StSend,
      StDone
   } state_t;

   state_t     state_q, state_d;
   logic       pending_q, pending_d;
   logic [7:0] count_q, count_d;
   logic [7:0] index_q, index_d;
   logic [7:0] tx_data_q, tx_data_d;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q   <= StIdle;
         pending_q <= 1'b0;
         count_q   <= 8'h00;
         index_q   <= 8'h00;
         tx_data_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         count_q   <= count_d;
         index_q   <= index_d;
         tx_data_q <= tx_data_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      count_d   = count_q;
      index_d   = index_q;
      tx_data_d = tx_data_q;

      // A request only registers while idle; it waits there until the arbiter allows us.
      if (state_q == StIdle && bus.Start) begin
         pending_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (pending_q && bus.Enable) begin
               state_d   = StReq;
               pending_d = 1'b0;
            end
         end
         StReq: begin
            if (bus.Bus_grant) begin
               state_d = StRdLen;
            end
         end
         StRdLen: begin
            state_d = StLatLen;
         end
         StLatLen: begin
            count_d = bus.Databus_in;
            index_d = 8'h00;
            state_d = (bus.Databus_in == 8'h00) ? StDone : StRdData;
         end
         StRdData: begin
            state_d = StLatData;
         end
         StLatData: begin
            tx_data_d = bus.Databus_in;
            state_d   = StSend;
         end
         StSend: begin
            if (bus.Ack_in) begin
               count_d = count_q - 8'd1;
               index_d = index_q + 8'd1;
               state_d = (count_q == 8'd1) ? StDone : StRdData;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // RAM strobes are pure state decodes so reset clears them on the very next edge.
   always_comb begin
      bus.Address = 8'h00;
      bus.Cs      = 1'b0;
      if (state_q == StRdLen) begin
         bus.Address = LEN_ADDR;
         bus.Cs      = 1'b1;
      end else if (state_q == StRdData) begin
         bus.Address = BASE_ADDR + index_q;
         bus.Cs      = 1'b1;
      end
   end

   assign bus.Oen     = bus.Cs;
   assign bus.Bus_req = (state_q != StIdle) && (state_q != StDone);
   assign bus.TX_Data = tx_data_q;
   assign bus.Valid_D = (state_q == StSend);
   assign bus.Ready   = (state_q == StDone);

endmodule

// File: tb/tb_dma_tx.sv
// Randomised bench for dma_tx: RAM model, arbiter/transmitter drivers and a scoreboard
// fed with read addresses, payload bytes and Ready tokens computed from the RAM image.
module tb_dma_tx;
   localparam int LenAddr  = 3;
   localparam int BaseAddr = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dma_tx_if bus ();

   dma_tx u_dut (
      .Clk (clk),
      .Rst (rst),
      .bus (bus.master)
   );

   logic [7:0] ram [256];

   // Synchronous RAM: data for a strobed address appears the following cycle.
   always @(posedge clk) begin
      if (bus.Cs) bus.Databus_in <= ram[bus.Address];
   end

   int n_chk  = 0;
   int n_pass = 0;

   int exp_addr[$];
   int exp_byte[$];
   int exp_ready = 0;
   int n_reads   = 0;
   int n_sends   = 0;

   bit mon_en    = 1'b0;
   bit rand_mode = 1'b0;
   bit en_fix    = 1'b1;
   bit gnt_fix   = 1'b1;
   bit ack_en    = 1'b1;
   bit spur_en   = 1'b0;
   int ack_min   = 0;
   int ack_max   = 3;
   int vcnt      = 0;
   int dly       = 0;

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                    name, act, act, exp, exp, $time);
   endtask

   // Arbiter and transmitter side, driven 1 time unit after each rising edge.
   initial begin
      bus.Enable    = 1'b0;
      bus.Bus_grant = 1'b0;
      bus.Ack_in    = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rand_mode) begin
            bus.Enable    = ($urandom_range(0, 3) != 0);
            bus.Bus_grant = ($urandom_range(0, 1) == 1);
         end else begin
            bus.Enable    = en_fix;
            bus.Bus_grant = gnt_fix;
         end
         if (bus.Valid_D) begin
            if (vcnt == 0) dly = $urandom_range(ack_min, ack_max);
            bus.Ack_in = ack_en && (vcnt >= dly);
            vcnt++;
         end else begin
            bus.Ack_in = spur_en && ($urandom_range(0, 3) == 0);
            vcnt = 0;
         end
      end
   end

   // Monitor / scoreboard.
   initial begin
      int  a;
      int  b;
      bit  prev_valid = 1'b0;
      bit  prev_ack   = 1'b0;
      int  prev_data  = 0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (bus.Cs) begin
               n_reads++;
               chk(bus.Oen == 1'b1, "oen_follows_cs", int'(bus.Oen), 1);
               if (exp_addr.size() == 0) begin
                  chk(1'b0, "unexpected_read", int'(bus.Address), -1);
               end else begin
                  a = exp_addr.pop_front();
                  chk(int'(bus.Address) == a, "read_addr", int'(bus.Address), a);
               end
            end else begin
               chk(bus.Address == 8'h00 && bus.Oen == 1'b0, "bus_idle_addr",
                   int'(bus.Address), 0);
            end
            if (bus.Valid_D && prev_valid && !prev_ack) begin
               chk(int'(bus.TX_Data) == prev_data, "tx_data_stable", int'(bus.TX_Data),
                   prev_data);
            end
            if (bus.Valid_D && bus.Ack_in) begin
               n_sends++;
               if (exp_byte.size() == 0) begin
                  chk(1'b0, "unexpected_send", int'(bus.TX_Data), -1);
               end else begin
                  b = exp_byte.pop_front();
                  chk(int'(bus.TX_Data) == b, "tx_data", int'(bus.TX_Data), b);
               end
            end
            if (bus.Ready) begin
               chk(exp_ready > 0, "ready_expected", 1, int'(exp_ready > 0));
               chk(bus.Bus_req == 1'b0, "bus_req_in_done", int'(bus.Bus_req), 0);
               if (exp_ready > 0) exp_ready--;
            end
         end
         prev_valid = bus.Valid_D;
         prev_ack   = bus.Ack_in;
         prev_data  = int'(bus.TX_Data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Reference model: one length read, then len payload reads wrapping modulo 256.
   task automatic load(input int len);
      int         a;
      logic [7:0] d;
      ram[LenAddr] = 8'(len);
      exp_addr.push_back(LenAddr);
      for (int i = 0; i < len; i++) begin
         a       = (BaseAddr + i) % 256;
         d       = 8'($urandom);
         ram[a]  = d;
         exp_addr.push_back(a);
         exp_byte.push_back(int'(d));
      end
      exp_ready++;
   endtask

   task automatic pulse_start();
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
   endtask

   task automatic apply_reset(input bit with_start);
      rst       = 1'b1;
      bus.Start = with_start;
      exp_addr.delete();
      exp_byte.delete();
      exp_ready = 0;
      tick();
      rst       = 1'b0;
      bus.Start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit xtra);
      int n = 0;
      while (exp_ready != 0 && n < budget) begin
         bus.Start = xtra && bus.Bus_req && ($urandom_range(0, 7) == 0);
         tick();
         n++;
      end
      bus.Start = 1'b0;
      chk(exp_ready == 0, "xfer_complete", exp_ready, 0);
      if (exp_ready != 0) apply_reset(1'b0);
   endtask

   task automatic wait_valid(input int budget);
      int n = 0;
      while (!bus.Valid_D && n < budget) begin
         tick();
         n++;
      end
      chk(bus.Valid_D == 1'b1, "valid_reached", int'(bus.Valid_D), 1);
   endtask

   function automatic int outs();
      logic [20:0] v;
      v = {bus.Address, bus.Cs, bus.Oen, bus.Bus_req, bus.TX_Data, bus.Valid_D, bus.Ready};
      return int'(v);
   endfunction

   initial begin
      int  r0;
      int  s0;
      int  cyc;
      int  len;
      bit  seen;
      bit  stable;
      int  held;

      rst       = 1'b1;
      bus.Start = 1'b1;  // coincident with reset, must be discarded
      repeat (3) tick();
      rst       = 1'b0;
      bus.Start = 1'b0;
      chk(outs() == 0, "reset_outputs", outs(), 0);
      mon_en = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         tick();
         seen |= bus.Bus_req;
      end
      chk(!seen, "start_in_reset_dropped", int'(seen), 0);

      // Single byte, ack two cycles into Valid_D.
      ack_min = 2;
      ack_max = 2;
      r0 = n_reads;
      s0 = n_sends;
      load(1);
      pulse_start();
      wait_done(200, 1'b0);
      chk(n_reads - r0 == 2, "single_reads", n_reads - r0, 2);
      chk(n_sends - s0 == 1, "single_sends", n_sends - s0, 1);
      tick();
      chk(bus.Bus_req == 1'b0, "single_bus_req_after", int'(bus.Bus_req), 0);

      // Zero length: Ready four edges after the Start edge (three after grant in REQ).
      r0 = n_reads;
      s0 = n_sends;
      load(0);
      pulse_start();
      cyc = 0;
      while (!bus.Ready && cyc < 20) begin
         tick();
         cyc++;
      end
      chk(cyc == 4, "zero_len_ready_latency", cyc, 4);
      wait_done(50, 1'b0);
      chk(n_reads - r0 == 1, "zero_len_reads", n_reads - r0, 1);
      chk(n_sends - s0 == 0, "zero_len_sends", n_sends - s0, 0);

      // Deferred start while Enable is low, then a second Start during SEND.
      ack_min = 0;
      ack_max = 3;
      en_fix  = 1'b0;
      tick();
      load(3);
      pulse_start();
      seen = 1'b0;
      repeat (10) begin
         tick();
         seen |= bus.Bus_req;
      end
      chk(!seen, "deferred_no_req", int'(seen), 0);
      en_fix = 1'b1;
      tick();
      chk(bus.Enable == 1'b1 && bus.Bus_req == 1'b0, "enable_rise_still_idle",
          int'(bus.Bus_req), 0);
      tick();
      chk(bus.Bus_req == 1'b1, "req_after_enable", int'(bus.Bus_req), 1);
      wait_valid(100);
      pulse_start();
      wait_done(300, 1'b0);
      seen = 1'b0;
      repeat (10) begin
         tick();
         seen |= bus.Bus_req;
      end
      chk(!seen, "second_start_ignored", int'(seen), 0);

      // Backpressure: Ack withheld for 50 cycles.
      ack_en = 1'b0;
      load(2);
      pulse_start();
      wait_valid(100);
      held   = int'(bus.TX_Data);
      r0     = n_reads;
      stable = 1'b1;
      repeat (50) begin
         tick();
         stable &= bus.Valid_D && (int'(bus.TX_Data) == held);
      end
      chk(stable, "backpressure_hold", int'(stable), 1);
      chk(n_reads == r0, "backpressure_no_reads", n_reads - r0, 0);
      ack_en = 1'b1;
      wait_done(300, 1'b0);

      // Reset in the middle of SEND.
      ack_en = 1'b0;
      load(4);
      pulse_start();
      wait_valid(100);
      apply_reset(1'b0);
      chk(outs() == 0, "reset_mid_send_outputs", outs(), 0);
      ack_en = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         tick();
         seen |= bus.Bus_req | bus.Ready;
      end
      chk(!seen, "no_activity_after_reset", int'(seen), 0);
      s0 = n_sends;
      load(1);
      pulse_start();
      wait_done(200, 1'b0);
      chk(n_sends - s0 == 1, "restart_after_reset", n_sends - s0, 1);

      // Maximum length; payload addresses run 04..FF then wrap to 00..02.
      ack_min = 0;
      ack_max = 1;
      s0 = n_sends;
      load(255);
      pulse_start();
      wait_done(5000, 1'b0);
      chk(n_sends - s0 == 255, "max_len_sends", n_sends - s0, 255);

      // Randomised transfers with random arbitration, ack delay and spurious acks.
      rand_mode = 1'b1;
      spur_en   = 1'b1;
      ack_max   = 4;
      for (int t = 0; t < 25; t++) begin
         len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(13, 60))
                                           : int'($urandom_range(0, 12));
         load(len);
         pulse_start();
         wait_done(4000, 1'b1);
      end
      rand_mode = 1'b0;
      spur_en   = 1'b0;
      repeat (5) tick();

      chk(exp_addr.size() == 0, "addr_queue_drained", exp_addr.size(), 0);
      chk(exp_byte.size() == 0, "byte_queue_drained", exp_byte.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass,
               n_chk);
      $fatal(1, "watchdog");
   end

endmodule
